// File: rtl/mips_pkg.sv
// +----------------------------------------------------------------------------+
// | mips_pkg : shared encodings for the mips multicycle control path           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_HALT   = 4'd12
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mips_alu_dec.sv
// +----------------------------------------------------------------------------+
// | mips_alu_dec : R-type funct field to ALU operation decode                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
// +----------------------------------------------------------------------------+
// | mips_mc_ctrl : multicycle main control FSM with memory-wait watchdog       |
// | Option: MIPS_MC_ILLEGAL_TRAP_EN halts on an unlisted opcode.   Rev 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_ctrl,
  output logic       halted,
  output logic [3:0] state_dbg
);

  localparam logic [8:0] WAIT_LIMIT = 9'(MEM_WAIT_MAX);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] exec_alu_ctrl;
  logic       strobe_state;
  logic       timeout;
  logic       unused_zero;

  // Branch resolution happens in the datapath; the flag is not consumed here.
  assign unused_zero = zero;

  mips_alu_dec u_alu_dec (
    .funct    (funct),
    .alu_ctrl (exec_alu_ctrl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // A ready in the limit cycle still wins over the timeout.
  always_comb begin
    strobe_state = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);
    timeout      = strobe_state && !mem_ready && (({1'b0, wait_cnt_q} + 9'd1) >= WAIT_LIMIT);
    wait_cnt_d   = (strobe_state && !mem_ready && !timeout) ? wait_cnt_q + 8'd1 : 8'd0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready)    state_d = ST_DECODE;
        else if (timeout) state_d = ST_HALT;
      end
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            state_d = ST_HALT;
`else
            state_d = ST_FETCH;
`endif
          end
        endcase
      end
      ST_MEMADR: state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD: begin
        if (mem_ready)    state_d = ST_MEMWB;
        else if (timeout) state_d = ST_HALT;
      end
      ST_MEMWR: begin
        if (mem_ready)    state_d = ST_FETCH;
        else if (timeout) state_d = ST_HALT;
      end
      ST_MEMWB:  state_d = ST_FETCH;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ALUWB:  state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_HALT;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_src        = PCSRC_ALU;
    alu_ctrl      = ALU_ADD;
    halted        = 1'b0;
    state_dbg     = state_q;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: alu_src_b = SRCB_IMM_SH2;
      ST_MEMADR, ST_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = exec_alu_ctrl;
      end
      ST_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
      end
      ST_ADDIWB: reg_write = 1'b1;
      ST_HALT:   halted    = 1'b1;
      default:   halted    = 1'b1;
    endcase
    // Async reset holds state at FETCH, so only the fetch-state drives need masking.
    if (reset) begin
      pc_write  = 1'b0;
      mem_read  = 1'b0;
      ir_write  = 1'b0;
      alu_src_b = SRCB_FOUR;
      state_dbg = ST_FETCH;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_mips_mc_ctrl : directed and randomized checks of mips_mc_ctrl           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mips_mc_ctrl;

  localparam int MAX = 4;

  // Phase numbers follow the state listing order of the control unit.
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                 P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_JUMP = 9,
                 P_ADDIEX = 10, P_ADDIWB = 11, P_HALT = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, halted;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  mips_mc_ctrl #(.MEM_WAIT_MAX(MAX)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_ctrl(alu_ctrl), .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int ph       = P_FETCH;
  int wcnt     = 0;
  int q[$];
  bit model_on = 1'b0;

  function automatic logic [2:0] funct_op(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // {pcw, pcwc, iord, mr, mw, irw, rw, rdst, m2r, asa, asb[2], pcs[2], alu[3], halted, state[4]}
  function automatic logic [21:0] exp_out(input int p, input logic rdy,
                                          input logic [5:0] fn, input logic rst);
    logic pcw, pcwc, io, mr, mw, irw, rw, rd, m2r, asa, h;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    logic [3:0] st;
    pcw = 0; pcwc = 0; io = 0; mr = 0; mw = 0; irw = 0; rw = 0; rd = 0; m2r = 0;
    asa = 0; h = 0; asb = 2'b00; pcs = 2'b00; alu = 3'b010; st = 4'(p);
    if (rst) begin
      asb = 2'b01;
      st  = 4'd0;
    end else begin
      case (p)
        P_FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
        P_DECODE: asb = 2'b11;
        P_MEMADR, P_ADDIEX: begin asa = 1; asb = 2'b10; end
        P_MEMRD:  begin mr = 1; io = 1; end
        P_MEMWB:  begin rw = 1; m2r = 1; end
        P_MEMWR:  begin mw = 1; io = 1; end
        P_EXEC:   begin asa = 1; alu = funct_op(fn); end
        P_ALUWB:  begin rw = 1; rd = 1; end
        P_BRANCH: begin asa = 1; alu = 3'b110; pcwc = 1; pcs = 2'b01; end
        P_JUMP:   begin pcw = 1; pcs = 2'b10; end
        P_ADDIWB: rw = 1;
        P_HALT:   h = 1;
        default:  h = 1;
      endcase
    end
    return {pcw, pcwc, io, mr, mw, irw, rw, rd, m2r, asa, asb, pcs, alu, h, st};
  endfunction

  function automatic int pop_next();
    if (q.size() > 0) return q.pop_front();
    return P_FETCH;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      ph = P_FETCH; wcnt = 0; q.delete(); model_on = 1'b1;
    end else if (model_on) begin
      case (ph)
        P_HALT: ph = P_HALT;
        P_FETCH, P_MEMRD, P_MEMWR: begin
          if (mem_ready) begin
            wcnt = 0;
            ph = (ph == P_FETCH) ? P_DECODE : pop_next();
          end else begin
            wcnt++;
            if (wcnt >= MAX) begin ph = P_HALT; wcnt = 0; q.delete(); end
          end
        end
        P_DECODE: begin
          q.delete();
          case (opcode)
            6'b100011: begin q.push_back(P_MEMADR); q.push_back(P_MEMRD); q.push_back(P_MEMWB); end
            6'b101011: begin q.push_back(P_MEMADR); q.push_back(P_MEMWR); end
            6'b000000: begin q.push_back(P_EXEC); q.push_back(P_ALUWB); end
            6'b000100: q.push_back(P_BRANCH);
            6'b001000: begin q.push_back(P_ADDIEX); q.push_back(P_ADDIWB); end
            6'b000010: q.push_back(P_JUMP);
            default: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
              q.push_back(P_HALT);
`endif
            end
          endcase
          ph = pop_next();
        end
        default: ph = pop_next();
      endcase
    end
  end

  always @(negedge clk) begin
    logic [21:0] e, a;
    if (model_on) begin
      e = exp_out(ph, mem_ready, funct, reset);
      a = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_ctrl, halted, state_dbg};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL model_cmp t=%0t phase=%0d actual=%h expected=%h", $time, ph, a, e);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic rdy);
    @(posedge clk);
    #1 mem_ready = rdy;
    #1;
  endtask

  task automatic do_reset(input logic rdy_after);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_state", {28'd0, state_dbg}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_alu_src_b", {30'd0, alu_src_b}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0; mem_ready = rdy_after;
    #1;
  endtask

  // Walks one instruction with mem_ready=1, checking literal state order.
  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input int n, input logic [31:0] seq, input logic [2:0] exec_alu);
    logic [3:0] s;
    opcode = op; funct = fn;
    for (int i = 0; i < n; i++) begin
      s = seq[4*(n-1-i) +: 4];
      chk({nm, "_state"}, {28'd0, state_dbg}, {28'd0, s});
      chk({nm, "_reg_write"}, {31'd0, reg_write}, {31'd0, (s == 4 || s == 7 || s == 11)});
      chk({nm, "_pc_write_cond"}, {31'd0, pc_write_cond}, {31'd0, (s == 8)});
      chk({nm, "_mem_write"}, {31'd0, mem_write}, {31'd0, (s == 5)});
      if (s == 4) chk({nm, "_mem_to_reg"}, {31'd0, mem_to_reg}, 32'd1);
      if (s == 6) chk({nm, "_alu_ctrl"}, {29'd0, alu_ctrl}, {29'd0, exec_alu});
      if (s == 7) chk({nm, "_reg_dst"}, {31'd0, reg_dst}, 32'd1);
      if (s == 8) chk({nm, "_pc_src"}, {30'd0, pc_src}, 32'd1);
      if (s == 9) begin
        chk({nm, "_pc_src"}, {30'd0, pc_src}, 32'd2);
        chk({nm, "_pc_write"}, {31'd0, pc_write}, 32'd1);
      end
      if (i < n - 1) cyc(1'b1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mw_cycles;
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
    ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2a;

    reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", {28'd0, state_dbg}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_ir_write", {31'd0, ir_write}, 32'd0);
    chk("reset_alu_src_b", {30'd0, alu_src_b}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0; mem_ready = 1'b1;
    #1;

    run_instr("lw",    6'b100011, 6'h00, 6, 32'h012340, 3'b010);
    run_instr("slt",   6'b000000, 6'h2a, 5, 32'h01670,  3'b111);
    run_instr("fn3f",  6'b000000, 6'h3f, 5, 32'h01670,  3'b010);
    run_instr("addi",  6'b001000, 6'h00, 5, 32'h01ab0,  3'b010);
    run_instr("beq",   6'b000100, 6'h00, 4, 32'h0180,   3'b010);
    run_instr("j",     6'b000010, 6'h00, 4, 32'h0190,   3'b010);
    run_instr("sw",    6'b101011, 6'h00, 5, 32'h01250,  3'b010);

    // sw with three wait cycles in the write phase
    opcode = 6'b101011;
    cyc(1'b1); cyc(1'b1);
    mw_cycles = 0;
    cyc(1'b0); mw_cycles += int'(mem_write);
    cyc(1'b0); mw_cycles += int'(mem_write);
    cyc(1'b0); mw_cycles += int'(mem_write);
    cyc(1'b1); mw_cycles += int'(mem_write);
    cyc(1'b1);
    chk("sw_wait_mem_write_cycles", mw_cycles, 4);
    chk("sw_wait_state", {28'd0, state_dbg}, 32'd0);
    chk("sw_wait_halted", {31'd0, halted}, 32'd0);

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    run_instr("illegal", 6'b111111, 6'h00, 3, 32'h01c, 3'b010);
    chk("illegal_halted", {31'd0, halted}, 32'd1);
`else
    run_instr("illegal", 6'b111111, 6'h00, 3, 32'h010, 3'b010);
    chk("illegal_halted", {31'd0, halted}, 32'd0);
`endif
    do_reset(1'b0);

    // watchdog: mem_ready stuck low in FETCH
    chk("wd_fetch_mem_read", {31'd0, mem_read}, 32'd1);
    repeat (3) begin
      cyc(1'b0);
      chk("wd_still_fetch", {28'd0, state_dbg}, 32'd0);
    end
    cyc(1'b0);
    chk("wd_halt_state", {28'd0, state_dbg}, 32'd12);
    chk("wd_halted", {31'd0, halted}, 32'd1);
    repeat (2) begin
      cyc(1'b1);
      chk("wd_halt_sticky", {31'd0, halted}, 32'd1);
      chk("wd_halt_mem_read", {31'd0, mem_read}, 32'd0);
      chk("wd_halt_ir_write", {31'd0, ir_write}, 32'd0);
    end
    do_reset(1'b1);

    // reset asserted while waiting in MEMRD
    opcode = 6'b100011;
    cyc(1'b1); cyc(1'b1); cyc(1'b0);
    chk("memrd_state", {28'd0, state_dbg}, 32'd3);
    chk("memrd_iord", {31'd0, iord}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("memrd_rst_state", {28'd0, state_dbg}, 32'd0);
    chk("memrd_rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("memrd_rst_iord", {31'd0, iord}, 32'd0);
    chk("memrd_rst_alu_src_b", {30'd0, alu_src_b}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0; mem_ready = 1'b1;
    #1;
    chk("post_rst_fetch_strobe", {31'd0, mem_read}, 32'd1);

    // randomized traffic, checked cycle by cycle by the model
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #1;
      if (reset) reset = 1'b0;
      else if (ph == P_HALT || $urandom_range(0, 149) == 0) reset = 1'b1;
      mem_ready = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom_range(0, 1));
      if (ph == P_FETCH) begin
        if ($urandom_range(0, 7) == 0) opcode = 6'($urandom_range(0, 63));
        else opcode = ops[$urandom_range(0, 5)];
        if ($urandom_range(0, 4) == 0) funct = 6'($urandom_range(0, 63));
        else funct = fns[$urandom_range(0, 4)];
      end
    end

    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle main control unit for the `mips` core. It sequences the shared datapath (PC, single unified memory port, IR, register file, ALU) through fetch/decode/execute/memory/writeback states, one instruction at a time. It holds memory strobes across a `mem_ready` handshake with a watchdog, and emits every datapath enable and mux select. It sits between the IR opcode/funct fields and the datapath inside `mips`.

## Interface
- `MEM_WAIT_MAX`, default 15: max cycles a memory strobe may wait for `mem_ready` before timeout (1..255).
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `opcode` input 6: IR[31:26].
- `funct` input 6: IR[5:0].
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond` output 1: unconditional / branch PC enable.
- `iord` output 1: memory address from PC (0) or ALUOut (1).
- `mem_read`, `mem_write` output 1: memory strobes.
- `ir_write`, `reg_write` output 1: IR / register-file write enables.
- `reg_dst`, `mem_to_reg`, `alu_src_a` output 1: rt/rd, ALUOut/MDR, PC/A selects.
- `alu_src_b` output 2: 00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `pc_src` output 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `alu_ctrl` output 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `halted` output 1: core stopped (timeout or illegal op).
- `state_dbg` output 4: current state encoding.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB, HALT.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, add, `pc_src`=00. `ir_write` and `pc_write` are asserted only in the cycle where `mem_ready`=1, then the FSM goes to DECODE. Otherwise it stays in FETCH.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, add. Next state by opcode:
  - 100011 lw, 101011 sw → MEMADR
  - 000000 R → EXEC
  - 000100 beq → BRANCH
  - 001000 addi → ADDIEX
  - 000010 j → JUMP
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, add; lw → MEMRD, sw → MEMWR.
- MEMRD: `mem_read`=1, `iord`=1; stays until `mem_ready`, then MEMWB. MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1 → FETCH.
- MEMWR: `mem_write`=1, `iord`=1; stays until `mem_ready`, then FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl` from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other funct → add). Then ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0 → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_write_cond`=1, `pc_src`=01 → FETCH. The datapath ANDs `pc_write_cond` with `zero`; the block itself does not use `zero` except to pass it through.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, add → ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 → FETCH.
- JUMP: `pc_write`=1, `pc_src`=10 → FETCH.
- Watchdog: an 8-bit wait counter is cleared on entering any strobe state and increments each cycle `mem_ready`=0. When the count reaches `MEM_WAIT_MAX` with `mem_ready` still 0, the FSM goes to HALT.
- HALT: all enables and strobes 0, `halted`=1. HALT is left only by `reset`.
- Unlisted outputs in any state are 0; `alu_ctrl` is add when not otherwise specified.

## Timing
- State register and wait counter update on rising `clk`. Outputs are Moore-decoded from state; the only exception is FETCH `ir_write`/`pc_write`, which are also gated by `mem_ready`.
- Reset values, asynchronous:
  - state=FETCH, counter=0.
  - While `reset`=1, all enables and strobes are forced to 0, `halted`=0, selects are 0 except `alu_src_b`=01, and `state_dbg`=FETCH.
- Zero-wait CPI: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each wait cycle adds 1.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- `mem_ready`=1 in the same cycle the count reaches the limit: the access completes and there is no timeout.
- Reset asserted mid-instruction aborts it; the first FETCH strobe appears in the cycle after release.

## Configuration
- `MIPS_MC_ILLEGAL_TRAP_EN` defined: an unlisted opcode in DECODE → HALT with `halted`=1.
- Not defined: an unlisted opcode in DECODE → FETCH and executes as a 2-cycle NOP.

## Structure
- `mips_pkg`: opcode and funct constants, `alu_ctrl` encodings, state enum (4-bit), `alu_src_b`/`pc_src` select encodings.
- Sub-module `mips_alu_dec`: combinational funct→`alu_ctrl` decode for the EXEC state.

## Test plan
- Reset, then `mem_ready`=1 constant, opcode 100011 → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. `reg_write`=1 and `mem_to_reg`=1 only in MEMWB.
- R-type funct 101010 → `alu_ctrl`=111 in EXEC, and `reg_dst`=1 with `reg_write`=1 in ALUWB. funct 111111 → add (010).
- sw with `mem_ready` low for 3 cycles in MEMWR → `mem_write` held 4 cycles, then FETCH with no `halted`.
- `MEM_WAIT_MAX`=4 and `mem_ready` stuck 0 in FETCH → HALT after 4 cycles. `halted`=1 and all strobes stay 0 until reset.
- beq → `pc_write_cond`=1 and `pc_src`=01 for exactly one cycle. j → `pc_write`=1 and `pc_src`=10 for one cycle. Both take 3 cycles total.
- Opcode 111111 → HALT with the macro defined, NOP back to FETCH without it. Reset asserted in MEMRD → outputs immediately return to reset values.
